// File: rtl/ext_pkg.sv
// Shared definitions for the extend/align stream.
//   MODE_SIGN / MODE_ZERO : encodings of the per-word extension mode.
//   sat_max(w) / sat_min(w): largest positive / most negative two's-complement
//                            value of width w, returned in a SAT_MAX_W-wide
//                            vector. Callers keep the low w bits.
package ext_pkg;

    localparam logic MODE_SIGN = 1'b0;
    localparam logic MODE_ZERO = 1'b1;

    // Widest output word the saturation helpers can describe.
    localparam int SAT_MAX_W = 128;

    // 0111...1 in the low w bits, zeros above.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
        logic [SAT_MAX_W-1:0] v_s;
        v_s = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < w - 1) begin
                v_s[i] = 1'b1;
            end else begin
                v_s[i] = 1'b0;
            end
        end
        return v_s;
    endfunction

    // 1000...0 in the low w bits, zeros above.
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
        logic [SAT_MAX_W-1:0] v_s;
        v_s = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i == w - 1) begin
                v_s[i] = 1'b1;
            end else begin
                v_s[i] = 1'b0;
            end
        end
        return v_s;
    endfunction

endpackage

// File: rtl/shift_sat.sv
// Combinational left shift with overflow detection and optional saturation.
//   ext   : OUT_W-bit extended word
//   mode  : MODE_SIGN or MODE_ZERO (how ext was extended)
//   shift : requested left shift; values above OUT_W-1 are clamped
//   data  : shifted word, saturated when SAT_EN != 0 and ovf is set
//   ovf   : significant bits (or the sign) were lost by the shift
module shift_sat
    import ext_pkg::*;
#(
    parameter int OUT_W  = 48,
    parameter int SAT_EN = 1,
    parameter int SH_W   = $clog2(OUT_W)
) (
    input  logic [OUT_W-1:0] ext,
    input  logic             mode,
    input  logic [SH_W-1:0]  shift,
    output logic [OUT_W-1:0] data,
    output logic             ovf
);

    localparam logic [SH_W-1:0]      MAX_SH       = SH_W'(OUT_W - 1);
    localparam logic [SAT_MAX_W-1:0] SAT_MAX_WIDE = sat_max(OUT_W);
    localparam logic [SAT_MAX_W-1:0] SAT_MIN_WIDE = sat_min(OUT_W);
    localparam logic [OUT_W-1:0]     SAT_MAX_C    = SAT_MAX_WIDE[OUT_W-1:0];
    localparam logic [OUT_W-1:0]     SAT_MIN_C    = SAT_MIN_WIDE[OUT_W-1:0];

    logic [SH_W-1:0]  eff_shift_s;
    logic [OUT_W-1:0] shifted_s;
    logic [OUT_W-1:0] back_s;

    // Shift, detect loss by shifting back, then pick wrapped or saturated value.
    always_comb begin
        eff_shift_s = (shift > MAX_SH) ? MAX_SH : shift;
        shifted_s   = ext << eff_shift_s;
        // Undoing the shift must reproduce ext exactly; any difference means
        // bits fell off the top (or, in sign mode, the sign bit changed).
        if (mode == MODE_SIGN) begin
            back_s = $unsigned($signed(shifted_s) >>> eff_shift_s);
        end else begin
            back_s = shifted_s >> eff_shift_s;
        end
        ovf = (back_s != ext);
        if (ovf && (SAT_EN != 0)) begin
            case (mode)
                MODE_SIGN: data = ext[OUT_W-1] ? SAT_MIN_C : SAT_MAX_C;
                MODE_ZERO: data = {OUT_W{1'b1}};
                default:   data = shifted_s;
            endcase
        end else begin
            data = shifted_s;
        end
    end

endmodule

// File: rtl/ext_align_stream.sv
// Streaming sign/zero extender with per-word left alignment.
// Two-stage pipeline: S1 registers the extended word with its mode/shift,
// S2 registers the shifted (optionally saturated) result. No skid buffer:
// in_ready is combinational from out_ready through the stage-advance terms.
//   CLK, RST_n           : clock (rising edge), async active-low reset
//   in_valid/in_ready    : input handshake; in_data, in_mode, in_shift
//                          are sampled on an input transfer
//   out_valid/out_ready  : output handshake; out_data, out_ovf held while
//                          stalled
//   out_cnt              : number of completed output transfers (wraps)
// OUT_W must be >= IN_W.
module ext_align_stream
    import ext_pkg::*;
#(
    parameter int IN_W   = 24,
    parameter int OUT_W  = 48,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_mode,
    input  logic [$clog2(OUT_W)-1:0] in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         out_cnt
);

    localparam int SH_W = $clog2(OUT_W);

    logic             run_r;
    logic             s1_valid_r;
    logic [OUT_W-1:0] s1_ext_r;
    logic             s1_mode_r;
    logic [SH_W-1:0]  s1_shift_r;
    logic             s2_valid_r;
    logic [OUT_W-1:0] s2_data_r;
    logic             s2_ovf_r;
    logic [CNT_W-1:0] cnt_r;

    logic             adv1_s;
    logic             adv2_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [OUT_W-1:0] ext_s;
    logic [OUT_W-1:0] ss_data_s;
    logic             ss_ovf_s;

    // Stage-advance terms, handshake fires and the extended input word.
    always_comb begin
        adv2_s     = !s2_valid_r || out_ready;
        adv1_s     = !s1_valid_r || adv2_s;
        // run_r keeps the input closed until the first edge after reset.
        in_ready   = adv1_s && run_r;
        in_fire_s  = in_valid && in_ready;
        out_fire_s = s2_valid_r && out_ready;
        if (in_mode == MODE_SIGN) begin
            ext_s = OUT_W'($signed(in_data));
        end else begin
            ext_s = OUT_W'(in_data);
        end
    end

    // Reset-release flag: opens the input on the first edge after RST_n rises.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Stage 1: capture the extended word with its mode and shift.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s1_valid_r <= 1'b0;
            s1_ext_r   <= '0;
            s1_mode_r  <= MODE_SIGN;
            s1_shift_r <= '0;
        end else begin
            if (adv1_s) begin
                s1_valid_r <= in_fire_s;
            end
            if (in_fire_s) begin
                s1_ext_r   <= ext_s;
                s1_mode_r  <= in_mode;
                s1_shift_r <= in_shift;
            end
        end
    end

    shift_sat #(
        .OUT_W  (OUT_W),
        .SAT_EN (SAT_EN),
        .SH_W   (SH_W)
    ) u_shift_sat (
        .ext   (s1_ext_r),
        .mode  (s1_mode_r),
        .shift (s1_shift_r),
        .data  (ss_data_s),
        .ovf   (ss_ovf_s)
    );

    // Stage 2: capture the aligned result; holds while the output is stalled.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_ovf_r   <= 1'b0;
        end else begin
            if (adv2_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (adv2_s && s1_valid_r) begin
                s2_data_r <= ss_data_s;
                s2_ovf_r  <= ss_ovf_s;
            end
        end
    end

    // Output transfer counter; wraps silently.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_r <= '0;
        end else if (out_fire_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_data  = s2_data_r;
    assign out_ovf   = s2_ovf_r;
    assign out_cnt   = cnt_r;

endmodule
